// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard controller states and architectural constants.
package cpu_pkg;

  typedef enum logic {HZ_RUN, HZ_LU} hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes and memory-wait freezes,
// plus a saturating stall-cycle counter and a sticky freeze watchdog.
import cpu_pkg::*;

module hazard_stall_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32,
  parameter int WD_LIMIT   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RegRs,
  input  logic [4:0]       ID_RegRt,
  input  logic             ID_UseRt,
  input  logic [4:0]       EX_RegRd,
  input  logic             EX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             IM_stall,
  input  logic             DM_stall,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wd_err
);

  localparam logic [2:0]  LU_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [15:0] WD_TRIP = 16'(WD_LIMIT - 1);

  hz_state_e   state_q, state_d;
  logic [2:0]  lu_cnt_q, lu_cnt_d;
  logic        wd_err_q, wd_err_d;
  logic [15:0] wd_cnt;
  logic        freeze;
  logic        lu_hit;
  logic        bubble;

  assign freeze = IM_stall | DM_stall;
  assign lu_hit = EX_MemRead && (EX_RegRd != REG_ZERO) &&
                  ((EX_RegRd == ID_RegRs) || (ID_UseRt && (EX_RegRd == ID_RegRt)));
  // While in LU the bubble train runs regardless of what is now sitting in EX.
  assign bubble = (state_q == HZ_LU) || lu_hit;

  always_comb begin
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    if (freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Write = 1'b0;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_d     = HZ_RUN;
      lu_cnt_d    = 3'd0;
    end else if (bubble) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (state_q == HZ_LU) begin
        lu_cnt_d = lu_cnt_q - 3'd1;
        if (lu_cnt_q == 3'd1) begin
          state_d = HZ_RUN;
        end
      end else if (LU_BUBBLES > 1) begin
        state_d  = HZ_LU;
        lu_cnt_d = LU_INIT;
      end
    end
  end

  assign wd_err_d = wd_err_q | (freeze & (wd_cnt >= WD_TRIP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HZ_RUN;
      lu_cnt_q <= 3'd0;
      wd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PC_Write),
    .clr   (1'b0),
    .q     (stall_cycles)
  );

  hz_sat_counter #(.W(16)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze),
    .clr   (~freeze),
    .q     (wd_cnt)
  );

  assign wd_err = wd_err_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: three controller configurations share one stimulus stream and are
// compared every cycle against a bubble-debt model, plus directed hand-computed checks.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] idRegRs;
  logic [4:0] idRegRt;
  logic       idUseRt;
  logic [4:0] exRegRd;
  logic       exMemRead;
  logic       exBranchTaken;
  logic       imStall;
  logic       dmStall;

  logic        pcW[3];
  logic        ifidW[3];
  logic        ifidF[3];
  logic        idexF[3];
  logic        exmemW[3];
  logic        memwbW[3];
  logic        wdErr[3];
  logic [31:0] stallA;
  logic [3:0]  stallB;
  logic [31:0] stallC;

  int checks = 0;
  int errors = 0;

  // Model: per instance, the number of bubbles still owed, plus counter images.
  int     luB[3]    = '{1, 2, 3};
  longint cntMax[3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
  int     wdLim[3]  = '{255, 4, 4};
  int     bubblesLeft[3];
  longint stallModel[3];
  int     wdCntModel[3];
  bit     wdErrModel[3];

  hazard_stall_ctrl #(.LU_BUBBLES(1), .CNT_W(32), .WD_LIMIT(255)) dutA (
    .clk(clk), .rst_n(rst_n), .ID_RegRs(idRegRs), .ID_RegRt(idRegRt), .ID_UseRt(idUseRt),
    .EX_RegRd(exRegRd), .EX_MemRead(exMemRead), .EX_BranchTaken(exBranchTaken),
    .IM_stall(imStall), .DM_stall(dmStall), .PC_Write(pcW[0]), .IF_ID_Write(ifidW[0]),
    .IF_ID_Flush(ifidF[0]), .ID_EX_Flush(idexF[0]), .EX_MEM_Write(exmemW[0]),
    .MEM_WB_Write(memwbW[0]), .stall_cycles(stallA), .wd_err(wdErr[0]));

  hazard_stall_ctrl #(.LU_BUBBLES(2), .CNT_W(4), .WD_LIMIT(4)) dutB (
    .clk(clk), .rst_n(rst_n), .ID_RegRs(idRegRs), .ID_RegRt(idRegRt), .ID_UseRt(idUseRt),
    .EX_RegRd(exRegRd), .EX_MemRead(exMemRead), .EX_BranchTaken(exBranchTaken),
    .IM_stall(imStall), .DM_stall(dmStall), .PC_Write(pcW[1]), .IF_ID_Write(ifidW[1]),
    .IF_ID_Flush(ifidF[1]), .ID_EX_Flush(idexF[1]), .EX_MEM_Write(exmemW[1]),
    .MEM_WB_Write(memwbW[1]), .stall_cycles(stallB), .wd_err(wdErr[1]));

  hazard_stall_ctrl #(.LU_BUBBLES(3), .CNT_W(32), .WD_LIMIT(4)) dutC (
    .clk(clk), .rst_n(rst_n), .ID_RegRs(idRegRs), .ID_RegRt(idRegRt), .ID_UseRt(idUseRt),
    .EX_RegRd(exRegRd), .EX_MemRead(exMemRead), .EX_BranchTaken(exBranchTaken),
    .IM_stall(imStall), .DM_stall(dmStall), .PC_Write(pcW[2]), .IF_ID_Write(ifidW[2]),
    .IF_ID_Flush(ifidF[2]), .ID_EX_Flush(idexF[2]), .EX_MEM_Write(exmemW[2]),
    .MEM_WB_Write(memwbW[2]), .stall_cycles(stallC), .wd_err(wdErr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Write}.
  function automatic logic [5:0] expCtrl(int owed);
    bit hit;
    hit = exMemRead && (exRegRd != 5'd0) &&
          ((exRegRd == idRegRs) || (idUseRt && (exRegRd == idRegRt)));
    if (imStall || dmStall) return 6'b000000;
    if (exBranchTaken)      return 6'b111111;
    if (owed > 0 || hit)    return 6'b000111;
    return 6'b110011;
  endfunction

  function automatic logic [5:0] actCtrl(int i);
    return {pcW[i], ifidW[i], ifidF[i], idexF[i], exmemW[i], memwbW[i]};
  endfunction

  function automatic longint actStall(int i);
    case (i)
      0:       return longint'(stallA);
      1:       return longint'(stallB);
      default: return longint'(stallC);
    endcase
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 3; i++) begin
      bubblesLeft[i] = 0;
      stallModel[i]  = 0;
      wdCntModel[i]  = 0;
      wdErrModel[i]  = 1'b0;
    end
  endtask

  task automatic stepModel();
    logic [5:0] e;
    for (int i = 0; i < 3; i++) begin
      e = expCtrl(bubblesLeft[i]);
      if (e[5] == 1'b0 && stallModel[i] < cntMax[i]) stallModel[i]++;
      if (imStall || dmStall) begin
        if (wdCntModel[i] < 65535) wdCntModel[i]++;
        if (wdCntModel[i] >= wdLim[i]) wdErrModel[i] = 1'b1;
      end else begin
        wdCntModel[i] = 0;
        if (exBranchTaken)          bubblesLeft[i] = 0;
        else if (e[2])              bubblesLeft[i] = (bubblesLeft[i] > 0) ? bubblesLeft[i] - 1
                                                                            : luB[i] - 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int inst, input longint actual,
                             input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s inst%0d actual=%0h expected=%0h at %0t", name, inst, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic useRt,
                               input logic [4:0] rd, input logic memRead, input logic br,
                               input logic im, input logic dm);
    @(posedge clk);
    #2;
    idRegRs = rs; idRegRt = rt; idUseRt = useRt; exRegRd = rd;
    exMemRead = memRead; exBranchTaken = br; imStall = im; dmStall = dm;
  endtask

  task automatic applyNop(input int n);
    for (int k = 0; k < n; k++) applyStimulus(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic applyHit();
    applyStimulus(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    idRegRs = 5'd1; idRegRt = 5'd2; idUseRt = 1'b1; exRegRd = 5'd3;
    exMemRead = 1'b0; exBranchTaken = 1'b0; imStall = 1'b0; dmStall = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Model maintenance on the active edge; reset is asynchronous so it also applies at once.
  always @(posedge clk) begin
    if (!rst_n) resetModel();
    else        stepModel();
  end

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) resetModel();
    for (int i = 0; i < 3; i++) begin
      checkOutput("ctrl", i, longint'(actCtrl(i)), longint'(expCtrl(bubblesLeft[i])));
      checkOutput("stall_cycles", i, actStall(i), stallModel[i]);
      checkOutput("wd_err", i, longint'(wdErr[i]), longint'(wdErrModel[i]));
    end
  end

  initial begin
    int burst;
    logic im;
    rst_n = 1'b0;
    idRegRs = 5'd1; idRegRt = 5'd2; idUseRt = 1'b1; exRegRd = 5'd3;
    exMemRead = 1'b0; exBranchTaken = 1'b0; imStall = 1'b0; dmStall = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 0, longint'(stallA), 0);
    checkOutput("reset_pc", 0, longint'(pcW[0]), 1);
    #2 rst_n = 1'b1;

    // Single load-use hit: bubble counts follow LU_BUBBLES.
    applyHit();
    @(negedge clk);
    checkOutput("lu_pc", 0, longint'(pcW[0]), 0);
    checkOutput("lu_idex_flush", 0, longint'(idexF[0]), 1);
    applyNop(1);
    @(negedge clk);
    checkOutput("lu_after_pc", 0, longint'(pcW[0]), 1);
    checkOutput("lu2_second_pc", 1, longint'(pcW[1]), 0);
    applyNop(4);
    @(negedge clk);
    checkOutput("lu_stall", 0, longint'(stallA), 1);
    checkOutput("lu_stall", 1, longint'(stallB), 2);
    checkOutput("lu_stall", 2, longint'(stallC), 3);
    applyStimulus(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rt_unused_pc", 0, longint'(pcW[0]), 1);
    applyStimulus(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rt_used_pc", 0, longint'(pcW[0]), 0);
    applyNop(4);

    // Register zero and branch-beats-bubble.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("r0_pc", 0, longint'(pcW[0]), 1);
    applyStimulus(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("br_pc", 2, longint'(pcW[2]), 1);
    checkOutput("br_ifid_flush", 2, longint'(ifidF[2]), 1);
    checkOutput("br_idex_flush", 2, longint'(idexF[2]), 1);
    applyNop(1);
    @(negedge clk);
    checkOutput("br_no_train_pc", 2, longint'(pcW[2]), 1);

    // Data-memory freeze in the middle of a bubble train.
    doReset();
    applyHit();
    repeat (3) applyStimulus(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("freeze_exmem", 2, longint'(exmemW[2]), 0);
    applyNop(3);
    @(negedge clk);
    checkOutput("freeze_stall", 0, longint'(stallA), 4);
    checkOutput("freeze_stall", 1, longint'(stallB), 5);
    checkOutput("freeze_stall", 2, longint'(stallC), 6);

    // Watchdog trips at the limit and is sticky until reset.
    doReset();
    repeat (3) applyStimulus(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wd_early", 1, longint'(wdErr[1]), 0);
    applyStimulus(5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    applyNop(1);
    @(negedge clk);
    checkOutput("wd_trip", 1, longint'(wdErr[1]), 1);
    checkOutput("wd_no_trip", 0, longint'(wdErr[0]), 0);
    applyNop(2);
    @(negedge clk);
    checkOutput("wd_sticky", 1, longint'(wdErr[1]), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("wd_reset", 1, longint'(wdErr[1]), 0);
    checkOutput("wd_reset_stall", 1, longint'(stallB), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Counter saturation, then reset in the middle of a bubble train.
    repeat (20) applyHit();
    applyNop(1);
    @(negedge clk);
    checkOutput("sat_stall", 1, longint'(stallB), 15);
    checkOutput("nosat_stall", 0, longint'(stallA), 20);
    doReset();
    applyHit();
    applyNop(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midlu_reset_pc", 2, longint'(pcW[2]), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midlu_after_pc", 2, longint'(pcW[2]), 1);

    // Randomized traffic with small register numbers so hazards are frequent.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst == 0 && $urandom_range(0, 49) == 0) burst = $urandom_range(3, 8);
      im = (burst > 0) || ($urandom_range(0, 19) == 0);
      if (burst > 0) burst--;
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 9) == 0), im, 1'($urandom_range(0, 19) == 0));
      rst_n = ($urandom_range(0, 199) != 0);
    end
    applyNop(2);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
